// File: rtl/line_align_delay.sv
// line_align_delay: valid-sample counted delay line for {addr, data} pairs.
// A circular buffer is written on every accepted sample; once the history
// holds dly samples the entry written dly samples ago is emitted, so the
// address and data always leave together from the same buffer entry.
module line_align_delay #(
  parameter int DATA_W = 36,
  parameter int ADDR_W = 19,
  parameter int DEPTH  = 1024,
  parameter int PTR_W  = 10
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              in_valid,
  input  logic [DATA_W-1:0] in_data,
  input  logic [ADDR_W-1:0] in_addr,
  input  logic [PTR_W-1:0]  delay_len,
  input  logic              bypass,
  input  logic              restart,
  output logic              out_valid,
  output logic [DATA_W-1:0] out_data,
  output logic [ADDR_W-1:0] out_addr,
  output logic              filling
);

  localparam int ENT_W = ADDR_W + DATA_W;

  typedef enum logic [1:0] {IDLE, FILL, RUN} state_t;

  state_t             state_q, state_d;
  logic [PTR_W-1:0]   wptr_q, wptr_d;
  logic [PTR_W-1:0]   cnt_q, cnt_d;
  logic [PTR_W-1:0]   dly_q, dly_d;
  logic               out_valid_q, out_valid_d;
  logic [DATA_W-1:0]  out_data_q, out_data_d;
  logic [ADDR_W-1:0]  out_addr_q, out_addr_d;

  logic [ENT_W-1:0]   mem_q [DEPTH];
  logic [ENT_W-1:0]   rd_ent;
  logic [PTR_W-1:0]   dly_eff;
  logic [PTR_W-1:0]   rptr;
  logic               wr_en;
  logic               emit;

  // A restart (or reset) cycle drops its sample so stale history never leaks.
  assign wr_en   = in_valid & ~restart & reset;
  // In IDLE the delay is still being latched, so the first sample uses the
  // live request; afterwards only the latched copy matters.
  assign dly_eff = (state_q == IDLE) ? delay_len : dly_q;
  assign rptr    = wptr_q - dly_eff;
  assign rd_ent  = mem_q[rptr];

  // Buffer write: one entry per accepted sample, pointer wraps naturally.
  always_ff @(posedge clk) begin
    if (wr_en) mem_q[wptr_q] <= {in_addr, in_data};
  end

  // FSM next state, fill counter, pointer and delay latch.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    wptr_d  = wptr_q;
    dly_d   = dly_q;
    emit    = 1'b0;
    if (state_q == IDLE) dly_d = delay_len;
    if (restart) begin
      state_d = IDLE;
      cnt_d   = '0;
      wptr_d  = '0;
    end else if (in_valid) begin
      wptr_d = wptr_q + 1'b1;
      unique case (state_q)
        IDLE: begin
          cnt_d = '0;
          if (dly_eff == '0) begin
            state_d = RUN;
            emit    = 1'b1;
          end else begin
            state_d = FILL;
          end
        end
        FILL: begin
          // Sample k of the run lands here with cnt = k; sample dly is the
          // first one that has a partner dly samples back, so it emits.
          cnt_d = cnt_q + 1'b1;
          if (cnt_d == dly_q) begin
            state_d = RUN;
            emit    = 1'b1;
          end
        end
        RUN:     emit = 1'b1;
        default: state_d = IDLE;
      endcase
    end
  end

  // Output register: bypass echoes the input, otherwise emit the aligned
  // entry; zero delay forwards the input to avoid reading the slot being written.
  always_comb begin
    out_valid_d = 1'b0;
    out_data_d  = out_data_q;
    out_addr_d  = out_addr_q;
    if (bypass) begin
      out_valid_d = in_valid;
      if (in_valid) begin
        out_data_d = in_data;
        out_addr_d = in_addr;
      end
    end else if (emit) begin
      out_valid_d = 1'b1;
      if (dly_eff == '0) begin
        out_data_d = in_data;
        out_addr_d = in_addr;
      end else begin
        {out_addr_d, out_data_d} = rd_ent;
      end
    end
  end

  // State and output registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q     <= IDLE;
      wptr_q      <= '0;
      cnt_q       <= '0;
      dly_q       <= '0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_addr_q  <= '0;
    end else begin
      state_q     <= state_d;
      wptr_q      <= wptr_d;
      cnt_q       <= cnt_d;
      dly_q       <= dly_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      out_addr_q  <= out_addr_d;
    end
  end

  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign out_addr  = out_addr_q;
  assign filling   = (state_q == FILL);

endmodule

// File: tb/tb_line_align_delay.sv
// Bench for line_align_delay: a history-queue model of the delay line is
// compared every cycle, plus literal pins at key points of each scenario.
module tb_line_align_delay;

  logic        clk;
  logic        reset;
  logic        in_valid;
  logic [35:0] in_data;
  logic [18:0] in_addr;
  logic [9:0]  delay_len;
  logic        bypass;
  logic        restart;
  logic        out_valid;
  logic [35:0] out_data;
  logic [18:0] out_addr;
  logic        filling;

  int tests = 0;
  int fails = 0;

  line_align_delay dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_data(in_data),
    .in_addr(in_addr), .delay_len(delay_len), .bypass(bypass),
    .restart(restart), .out_valid(out_valid), .out_data(out_data),
    .out_addr(out_addr), .filling(filling)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s at %0t: got %0h expected %0h", nm, $time, act, exp);
    end
  endtask

  // Model: list of samples accepted since the last restart; sample n emits
  // sample n-d once n >= d, where d is the delay seen at the first sample.
  logic [54:0] hist[$];
  int          n_acc = 0;
  int          dm = 0;
  logic        armed = 1'b0;
  logic        exp_v = 1'b0;
  logic [35:0] exp_d = '0;
  logic [18:0] exp_a = '0;
  logic        exp_f = 1'b0;

  always @(posedge clk) begin
    int deff;
    if (!reset) begin
      armed = 1'b1;
      hist.delete();
      n_acc = 0; dm = 0;
      exp_v = 1'b0; exp_d = '0; exp_a = '0; exp_f = 1'b0;
    end else begin
      deff  = (n_acc == 0) ? int'(delay_len) : dm;
      exp_v = 1'b0;
      if (restart) begin
        hist.delete();
        n_acc = 0;
      end else if (in_valid) begin
        if (n_acc == 0) dm = int'(delay_len);
        hist.push_back({in_addr, in_data});
        if (!bypass && n_acc >= deff) begin
          exp_v = 1'b1;
          {exp_a, exp_d} = hist[n_acc - deff];
        end
        n_acc++;
      end
      if (bypass) begin
        exp_v = in_valid;
        if (in_valid) begin
          exp_d = in_data;
          exp_a = in_addr;
        end
      end
      exp_f = (n_acc >= 1) && (n_acc <= dm);
    end
  end

  // Per-cycle comparison against the model.
  always @(negedge clk) begin
    if (armed) begin
      chk("out_valid", 64'(out_valid), 64'(exp_v));
      chk("out_data",  64'(out_data),  64'(exp_d));
      chk("out_addr",  64'(out_addr),  64'(exp_a));
      chk("filling",   64'(filling),   64'(exp_f));
    end
  end

  function automatic logic [18:0] addr_of(input int v);
    return 19'(v * 3);
  endfunction

  // Present one cycle of input, then return 1 time unit after the edge.
  task automatic send(input logic v, input int val);
    in_valid = v;
    in_data  = 36'(val);
    in_addr  = addr_of(val);
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_restart();
    restart = 1'b1;
    send(1'b1, 77);
    restart = 1'b0;
  endtask

  initial begin
    reset = 1'b0; in_valid = 1'b0; in_data = '0; in_addr = '0;
    delay_len = '0; bypass = 1'b0; restart = 1'b0;
    repeat (3) send(1'b0, 0);
    chk("rst_out_valid", 64'(out_valid), 64'd0);
    chk("rst_out_data",  64'(out_data),  64'd0);
    chk("rst_filling",   64'(filling),   64'd0);
    reset = 1'b1;

    // Zero delay: each sample one cycle later.
    for (int i = 0; i < 8; i++) begin
      send(1'b1, 'h55 + i);
      if (i == 0) begin
        chk("d0_first_valid", 64'(out_valid), 64'd1);
        chk("d0_first_data",  64'(out_data),  64'h55);
      end
    end
    send(1'b0, 0);

    // Delay 4 with alternating gaps; a mid-run delay_len change is ignored.
    delay_len = 10'd4;
    pulse_restart();
    for (int k = 0; k < 40; k++) begin
      if (k == 10) delay_len = 10'd9;
      send(k % 2 == 0, 300 + k / 2);
      if (k == 8) chk("d4_first_data", 64'(out_data), 64'd300);
      if (k == 9) begin
        chk("d4_gap_valid", 64'(out_valid), 64'd0);
        chk("d4_gap_hold",  64'(out_data),  64'd300);
      end
    end

    // Delay 640, 2000 samples, then a bypass window inside RUN.
    delay_len = 10'd640;
    pulse_restart();
    for (int i = 0; i < 2000; i++) begin
      send(1'b1, i);
      if (i == 639) begin
        chk("d640_pre_valid", 64'(out_valid), 64'd0);
        chk("d640_pre_fill",  64'(filling),   64'd1);
      end
      if (i == 640) begin
        chk("d640_first_valid", 64'(out_valid), 64'd1);
        chk("d640_first_data",  64'(out_data),  64'd0);
        chk("d640_first_addr",  64'(out_addr),  64'd0);
        chk("d640_fill_off",    64'(filling),   64'd0);
      end
    end
    bypass = 1'b1;
    for (int i = 2000; i < 2010; i++) begin
      send(1'b1, i);
      if (i == 2000) chk("byp_echo", 64'(out_data), 64'd2000);
    end
    bypass = 1'b0;
    for (int i = 2010; i < 2030; i++) begin
      send(1'b1, i);
      if (i == 2010) chk("byp_resume", 64'(out_data), 64'd1370);
    end

    // Restart at sample 700 of a 640 run; no pre-restart data afterwards.
    pulse_restart();
    for (int i = 0; i <= 700; i++) send(1'b1, 5000 + i);
    pulse_restart();
    chk("rs_drop_valid", 64'(out_valid), 64'd0);
    for (int i = 0; i <= 700; i++) begin
      send(1'b1, 20000 + i);
      if (i == 639) chk("rs_refill_valid", 64'(out_valid), 64'd0);
      if (i == 640) chk("rs_refill_data",  64'(out_data),  64'd20000);
    end

    // Reset mid-stream behaves like restart and clears outputs.
    reset = 1'b0;
    send(1'b1, 5);
    reset = 1'b1;
    chk("mid_rst_valid", 64'(out_valid), 64'd0);
    chk("mid_rst_data",  64'(out_data),  64'd0);

    // Maximum delay across pointer wrap.
    delay_len = 10'd1023;
    for (int i = 0; i < 3000; i++) begin
      send(1'b1, 40000 + i);
      if (i == 1022) chk("wrap_pre_valid", 64'(out_valid), 64'd0);
      if (i == 2999) begin
        chk("wrap_last_data", 64'(out_data), 64'(40000 + 1976));
        chk("wrap_last_addr", 64'(out_addr), 64'(addr_of(40000 + 1976)));
      end
    end
    send(1'b0, 0);
    send(1'b0, 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
